// File: rtl/shift_rotate_pipe.sv
// Two-stage log-structured shifter/rotator with valid/ready on both sides.
// Optional zero-result flag: define SHIFT_ROTATE_PIPE_ZERO_FLAG_EN.
module shift_rotate_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFT_ROTATE_PIPE_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int LO = SHW / 2;
  localparam int HI = SHW - LO;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  function automatic logic [WIDTH-1:0] shf(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic [SHW-1:0]   a
  );
    logic [2*WIDTH-1:0] dd;
    logic [WIDTH-1:0]   r;
    dd = '0;
    r  = d;
    unique case (op)
      OP_ROL: begin
        dd = {d, d} << a;
        r  = dd[2*WIDTH-1:WIDTH];
      end
      OP_SLL: r = d << a;
      OP_ROR: begin
        dd = {d, d} >> a;
        r  = dd[WIDTH-1:0];
      end
      OP_SRL: r = d >> a;
    endcase
    return r;
  endfunction

  logic             s1_v_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [1:0]       s1_op_q;
  logic [HI-1:0]    s1_hi_q;
  logic             s2_v_q;
  logic [WIDTH-1:0] s2_data_q;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] s1_data_d;
  logic [WIDTH-1:0] s2_data_d;

  assign adv2     = !s2_v_q || out_ready;
  assign adv1     = !s1_v_q || adv2;
  assign in_ready = adv1;

  // Same-direction partial shifts compose, so the low and high
  // amount bits can be applied in separate stages.
  assign s1_data_d = shf(in_data, in_op,
                         {{HI{1'b0}}, in_amt[LO-1:0]});
  assign s2_data_d = shf(s1_data_q, s1_op_q,
                         {s1_hi_q, {LO{1'b0}}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_op_q   <= '0;
      s1_hi_q   <= '0;
    end else if (adv1) begin
      s1_v_q    <= in_valid && in_ready;
      s1_data_q <= s1_data_d;
      s1_op_q   <= in_op;
      s1_hi_q   <= in_amt[SHW-1:LO];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
    end else if (adv2) begin
      s2_v_q    <= s1_v_q;
      s2_data_q <= s2_data_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;

`ifdef SHIFT_ROTATE_PIPE_ZERO_FLAG_EN
  logic s2_zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_zero_q <= 1'b0;
    end else if (adv2) begin
      s2_zero_q <= (s2_data_d == '0);
    end
  end

  assign out_zero = s2_zero_q;
`endif

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Directed bench for shift_rotate_pipe with a scoreboard model.
// Zero-flag checks active when SHIFT_ROTATE_PIPE_ZERO_FLAG_EN is defined.
module tb_shift_rotate_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [3:0]   in_amt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef SHIFT_ROTATE_PIPE_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int sw_cycles = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];
  bit           stab_pend = 0;
  logic [W-1:0] stab_val;

  shift_rotate_pipe #(.WIDTH(16), .SHW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_ROTATE_PIPE_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(
    input logic [W-1:0] d,
    input logic [1:0]   op,
    input int           a
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (op)
        2'd0: r[(i + a) % W] = d[i];
        2'd1: if (i + a < W) r[i + a] = d[i];
        2'd2: r[(i - a + W) % W] = d[i];
        default: if (i - a >= 0) r[i - a] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stab_pend = 0;
    end else begin
      if (stab_pend) chk("stall_stable", out_data, stab_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_data, 32'hDEAD);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("scoreboard", out_data, e);
`ifdef SHIFT_ROTATE_PIPE_ZERO_FLAG_EN
          chk("zero_flag", out_zero, e == '0);
`endif
        end
        n_out++;
        rx_q.push_back(out_data);
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_data, in_op, int'(in_amt)));
      stab_pend = out_valid && !out_ready;
      stab_val  = out_data;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [1:0] op,
                      input logic [3:0] a);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_amt   = a;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("accept_timeout", acc, 1);
    sw_cycles += n;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] e,
                            input bit ez);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk({nm, "_valid"}, out_valid, 1);
    chk(nm, out_data, e);
`ifdef SHIFT_ROTATE_PIPE_ZERO_FLAG_EN
    chk({nm, "_zero"}, out_zero, ez);
`else
    if (ez) n = 0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_amt = '0;
    in_op = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(16'h8001, 2'd0, 4'd1);
    idle();
    chk("lat_after_accept", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid, 1);
    chk("rol_8001_1", out_data, 16'h0003);
    @(posedge clk);
    #1;

    send(16'h00FF, 2'd1, 4'd12); idle();
    expect_out("sll_00ff_12", 16'hF000, 0);
    send(16'h8000, 2'd3, 4'd15); idle();
    expect_out("srl_8000_15", 16'h0001, 0);
    send(16'h1234, 2'd2, 4'd4); idle();
    expect_out("ror_1234_4", 16'h4123, 0);
    for (int op = 0; op < 4; op++) begin
      send(16'hA5C3, 2'(op), 4'd0); idle();
      expect_out("amt0", 16'hA5C3, 0);
    end
    drain();

    n0 = n_out;
    sw_cycles = 0;
    for (int op = 0; op < 4; op++)
      for (int a = 0; a < 16; a++)
        send(16'h9E37, 2'(op), 4'(a));
    idle();
    drain();
    chk("sweep_cycles", sw_cycles, 64);
    chk("sweep_outputs", n_out - n0, 64);

    out_ready = 1'b0;
    rx_q.delete();
    send(16'h0001, 2'd0, 4'd1);
    send(16'h0001, 2'd0, 4'd2);
    in_data = 16'h0001;
    in_amt = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 16'h0002);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0001, 2'd0, 4'd3);
    idle();
    drain();
    chk("stall_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("stall_o0", rx_q[0], 16'h0002);
      chk("stall_o1", rx_q[1], 16'h0004);
      chk("stall_o2", rx_q[2], 16'h0008);
    end

    out_ready = 1'b0;
    send(16'h0F0F, 2'd2, 4'd3);
    send(16'h1111, 2'd1, 4'd5);
    idle();
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
`ifdef SHIFT_ROTATE_PIPE_ZERO_FLAG_EN
    chk("arst_zero", out_zero, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    n0 = n_out;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale_out", n_out - n0, 0);
    chk("no_stale_valid", out_valid, 0);

`ifdef SHIFT_ROTATE_PIPE_ZERO_FLAG_EN
    send(16'h8000, 2'd1, 4'd1); idle();
    expect_out("zf_sll", 16'h0000, 1);
    send(16'h8000, 2'd0, 4'd1); idle();
    expect_out("zf_rol", 16'h0001, 0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
